// File: rtl/spirose_pkg.sv
// Shared spirose definitions: line-scheduler FSM states and default display geometry.
// Also referenced by driver_controller and framebuffer_emulator.
package spirose_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_DEAD      = 2'd2,
        ST_WAIT_SYNC = 2'd3
    } sched_state_t;

    localparam int NB_MUX_DEF    = 8;
    localparam int NB_SLICES_DEF = 128;
    localparam int DEAD_CNT_W    = 8;

endpackage

// File: rtl/mux_scheduler.sv
// LED line multiplexer scheduler: walks the lines of each angular slice with
// all-off dead time between lines, resynchronising to the rotation index pulse.
module mux_scheduler
    import spirose_pkg::*;
#(
    parameter int NB_MUX    = NB_MUX_DEF,
    parameter int DEAD_TIME = 4,
    parameter int NB_SLICES = NB_SLICES_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         position_sync,
    input  logic                         column_ready,
    output logic [NB_MUX-1:0]            mux_out,
    output logic [$clog2(NB_MUX)-1:0]    mux_index,
    output logic [$clog2(NB_SLICES)-1:0] slice_index,
    output logic                         slice_start,
    output logic                         sync_error
);

    localparam int MUX_W = $clog2(NB_MUX);
    localparam int SL_W  = $clog2(NB_SLICES);

    localparam logic [MUX_W-1:0]      LAST_MUX   = MUX_W'(NB_MUX - 1);
    localparam logic [SL_W-1:0]       LAST_SLICE = SL_W'(NB_SLICES - 1);
    localparam logic [DEAD_CNT_W-1:0] DEAD_LOAD  = DEAD_CNT_W'(DEAD_TIME);

    sched_state_t            state_q, state_d;
    logic [DEAD_CNT_W-1:0]   dead_cnt_q, dead_cnt_d;
    logic                    resync_q, resync_d;
    logic [MUX_W-1:0]        idx_d;
    logic [SL_W-1:0]         slice_d;
    logic                    start_d;
    logic                    err_d;
    logic [NB_MUX-1:0]       mux_out_d;

    function automatic logic [NB_MUX-1:0] onehot(input logic [MUX_W-1:0] idx);
        logic [NB_MUX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dead_cnt_q  <= '0;
            resync_q    <= 1'b0;
            mux_index   <= '0;
            slice_index <= '0;
            slice_start <= 1'b0;
            sync_error  <= 1'b0;
            mux_out     <= '0;
        end else begin
            state_q     <= state_d;
            dead_cnt_q  <= dead_cnt_d;
            resync_q    <= resync_d;
            mux_index   <= idx_d;
            slice_index <= slice_d;
            slice_start <= start_d;
            sync_error  <= err_d;
            mux_out     <= mux_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        resync_d   = resync_q;
        idx_d      = mux_index;
        slice_d    = slice_index;
        start_d    = 1'b0;
        err_d      = sync_error;

        if (!enable) begin
            state_d    = ST_IDLE;
            dead_cnt_d = '0;
            resync_d   = 1'b0;
            idx_d      = '0;
            slice_d    = '0;
            err_d      = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (position_sync) begin
                        state_d = ST_ACTIVE;
                        idx_d   = '0;
                        slice_d = '0;
                        start_d = 1'b1;
                    end
                end
                // An early sync beats column_ready: blank the line, then restart the rotation.
                ST_ACTIVE: begin
                    if (position_sync) begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = DEAD_LOAD;
                        err_d      = 1'b1;
                        resync_d   = 1'b1;
                    end else if (column_ready) begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = DEAD_LOAD;
                    end
                end
                ST_DEAD: begin
                    if (position_sync) begin
                        dead_cnt_d = DEAD_LOAD;
                        err_d      = 1'b1;
                        resync_d   = 1'b1;
                    end else if (dead_cnt_q > DEAD_CNT_W'(1)) begin
                        dead_cnt_d = dead_cnt_q - DEAD_CNT_W'(1);
                    end else begin
                        dead_cnt_d = '0;
                        state_d    = ST_ACTIVE;
                        if (resync_q) begin
                            resync_d = 1'b0;
                            idx_d    = '0;
                            slice_d  = '0;
                            start_d  = 1'b1;
                        end else if (mux_index != LAST_MUX) begin
                            idx_d = mux_index + MUX_W'(1);
                        end else if (slice_index != LAST_SLICE) begin
                            idx_d   = '0;
                            slice_d = slice_index + SL_W'(1);
                            start_d = 1'b1;
                        end else begin
                            idx_d   = '0;
                            state_d = ST_WAIT_SYNC;
                        end
                    end
                end
                ST_WAIT_SYNC: begin
                    if (position_sync) begin
                        state_d = ST_ACTIVE;
                        idx_d   = '0;
                        slice_d = '0;
                        start_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mux_out_d = '0;
        if (state_d == ST_ACTIVE)
            mux_out_d = onehot(idx_d);
    end

endmodule

// File: tb/tb_mux_scheduler.sv
// Scoreboard bench for mux_scheduler: a behavioural model predicts every cycle,
// plus directed checks on the scheduling scenarios with fixed expected values.
module tb_mux_scheduler;

    localparam int NB_MUX = 8;
    localparam int DT     = 4;
    localparam int NB_SL  = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       position_sync = 1'b0;
    logic       column_ready = 1'b0;
    logic [7:0] mux_out;
    logic [2:0] mux_index;
    logic [6:0] slice_index;
    logic       slice_start;
    logic       sync_error;

    mux_scheduler #(.NB_MUX(NB_MUX), .DEAD_TIME(DT), .NB_SLICES(NB_SL)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .position_sync(position_sync),
        .column_ready (column_ready),
        .mux_out      (mux_out),
        .mux_index    (mux_index),
        .slice_index  (slice_index),
        .slice_start  (slice_start),
        .sync_error   (sync_error)
    );

    always #15 clk = ~clk;

    typedef struct {
        logic [7:0] mo;
        logic [2:0] mi;
        logic [6:0] si;
        logic       ss;
        logic       se;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   zeros;
    int   starts;

    // model state: 0 idle, 1 active, 2 dead, 3 wait_sync
    int m_st, m_idx, m_sl, m_cnt;
    bit m_rs, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_idx = 0; m_sl = 0; m_cnt = 0; m_rs = 0; m_err = 0;
    endtask

    task automatic model_clk(input bit en, input bit ps, input bit cr, output exp_t e);
        bit ss;
        ss = 1'b0;
        if (!en) begin
            model_reset();
        end else begin
            case (m_st)
                0: if (ps) begin m_st = 1; m_idx = 0; m_sl = 0; ss = 1'b1; end
                1: if (ps || cr) begin
                       m_st = 2; m_cnt = DT;
                       if (ps) begin m_err = 1; m_rs = 1; end
                   end
                2: if (ps) begin
                       m_cnt = DT; m_err = 1; m_rs = 1;
                   end else if (m_cnt > 1) begin
                       m_cnt--;
                   end else begin
                       m_cnt = 0; m_st = 1;
                       if (m_rs) begin
                           m_rs = 0; m_idx = 0; m_sl = 0; ss = 1'b1;
                       end else if (m_idx < NB_MUX - 1) begin
                           m_idx++;
                       end else begin
                           m_idx = 0;
                           if (m_sl < NB_SL - 1) begin m_sl++; ss = 1'b1; end
                           else m_st = 3;
                       end
                   end
                3: if (ps) begin m_st = 1; m_idx = 0; m_sl = 0; ss = 1'b1; end
                default: m_st = 0;
            endcase
        end
        e.mo = (m_st == 1) ? 8'(1 << m_idx) : 8'h00;
        e.mi = 3'(m_idx);
        e.si = 7'(m_sl);
        e.ss = ss;
        e.se = m_err;
    endtask

    task automatic step(input bit en, input bit ps, input bit cr);
        exp_t e;
        @(negedge clk);
        enable = en; position_sync = ps; column_ready = cr;
        model_clk(en, ps, cr, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("mux_out", mux_out, e.mo);
            chk("mux_index", mux_index, e.mi);
            chk("slice_index", slice_index, e.si);
            chk("slice_start", slice_start, e.ss);
            chk("sync_error", sync_error, e.se);
        end
        if (mux_out == 8'h00) zeros++;
        if (slice_start) starts++;
    endtask

    task automatic column();
        step(1, 0, 1);
        repeat (DT) step(1, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mux_out", mux_out, 0);
        chk("rst_mux_index", mux_index, 0);
        chk("rst_slice_index", slice_index, 0);
        chk("rst_slice_start", slice_start, 0);
        chk("rst_sync_error", sync_error, 0);

        @(negedge clk);
        rst = 1'b0;
        repeat (9) step(1, 0, 0);
        chk("pre_sync_mux", mux_out, 8'h00);
        step(1, 1, 0);
        chk("sync_mux", mux_out, 8'h01);
        chk("sync_start", slice_start, 1);

        zeros = 0;
        step(1, 0, 1);
        repeat (DT - 1) step(1, 0, 0);
        chk("dead_len", zeros, 4);
        step(1, 0, 0);
        chk("line1_mux", mux_out, 8'h02);
        chk("line1_idx", mux_index, 1);

        starts = 0;
        repeat (NB_MUX - 1) column();
        chk("slice1_mux", mux_out, 8'h01);
        chk("slice1_idx", slice_index, 1);
        chk("slice1_starts", starts, 1);

        repeat ((NB_SL - 1) * NB_MUX) column();
        chk("wait_mux", mux_out, 8'h00);
        step(1, 0, 1);
        step(1, 0, 0);
        chk("wait_hold_mux", mux_out, 8'h00);
        chk("wait_slice", slice_index, NB_SL - 1);
        step(1, 1, 0);
        chk("resync_mux", mux_out, 8'h01);
        chk("resync_slice", slice_index, 0);
        chk("resync_err", sync_error, 0);
        chk("resync_start", slice_start, 1);

        repeat (5 * NB_MUX + 3) column();
        chk("pre_early_idx", mux_index, 3);
        chk("pre_early_slice", slice_index, 5);
        zeros = 0;
        step(1, 1, 1);
        chk("early_err", sync_error, 1);
        repeat (DT - 1) step(1, 0, 0);
        chk("early_dead_len", zeros, 4);
        step(1, 0, 0);
        chk("early_mux", mux_out, 8'h01);
        chk("early_slice", slice_index, 0);
        chk("early_start", slice_start, 1);
        chk("early_err_sticky", sync_error, 1);
        step(0, 0, 0);
        chk("dis_err", sync_error, 0);
        chk("dis_mux", mux_out, 8'h00);

        // early sync arriving inside the dead window reloads the dead time
        step(1, 1, 0);
        step(1, 0, 1);
        step(1, 0, 0);
        step(1, 1, 0);
        repeat (DT - 1) step(1, 0, 0);
        chk("dsync_still_dead", mux_out, 8'h00);
        step(1, 0, 0);
        chk("dsync_mux", mux_out, 8'h01);
        chk("dsync_err", sync_error, 1);

        step(1, 0, 1);
        step(1, 0, 0);
        @(negedge clk);
        enable = 1'b1; position_sync = 1'b0; column_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_mux", mux_out, 0);
        chk("arst_idx", mux_index, 0);
        chk("arst_slice", slice_index, 0);
        chk("arst_start", slice_start, 0);
        chk("arst_err", sync_error, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            step(1, 0, 1);
            chk("post_rst_mux", mux_out, 8'h00);
        end
        step(1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scheduler.md
MUX_SCHEDULER -- requirements
Module: mux_scheduler

Interface
REQ-001 Parameter NB_MUX, default 8: number of multiplexed LED lines.
REQ-002 Parameter DEAD_TIME, default 4: all-lines-off clock cycles between two active lines (legal range 1..255).
REQ-003 Parameter NB_SLICES, default 128: angular slices per rotation.
REQ-004 Port clk  input  1: single clock, the 33 MHz logic clock; all logic on its rising edge.
REQ-005 Port rst  input  1: reset, asynchronous and active-high.
REQ-006 Port enable  input  1: display enable (rgb_enable from the SPI decoder); level.
REQ-007 Port position_sync  input  1: one-cycle pulse marking rotation index 0.
REQ-008 Port column_ready  input  1: one-cycle pulse from driver_controller meaning the current line's data is shown and the next line is latched.
REQ-009 Port mux_out  output  NB_MUX: one-hot line select, or all zero.
REQ-010 Port mux_index  output  $clog2(NB_MUX): index of the current or next line.
REQ-011 Port slice_index  output  $clog2(NB_SLICES): current slice.
REQ-012 Port slice_start  output  1: one-cycle pulse when a new slice begins.
REQ-013 Port sync_error  output  1: sticky flag, rotation sync arrived out of sequence.

Function
REQ-014 The FSM has states IDLE, ACTIVE, DEAD and WAIT_SYNC; all outputs are registered and change 1 cycle after the causing input.
REQ-015 mux_out is onehot(mux_index) in ACTIVE and zero in IDLE, DEAD and WAIT_SYNC.
REQ-016 IDLE -> ACTIVE on enable=1 & position_sync=1, with mux_index=0, slice_index=0 and slice_start pulsed.
REQ-017 ACTIVE -> DEAD on column_ready, loading the dead-time counter with DEAD_TIME.
REQ-018 DEAD stays exactly DEAD_TIME cycles; column_ready in DEAD is ignored.
REQ-019 On DEAD exit with mux_index<NB_MUX-1: mux_index increments and the next state is ACTIVE.
REQ-020 On DEAD exit with mux_index=NB_MUX-1 and slice_index<NB_SLICES-1: mux_index=0, slice_index increments, slice_start pulses, and the next state is ACTIVE.
REQ-021 On DEAD exit with mux_index=NB_MUX-1 and slice_index=NB_SLICES-1: the next state is WAIT_SYNC, with mux_index=0 and slice_index held.
REQ-022 WAIT_SYNC -> ACTIVE on position_sync: slice_index=0, slice_start pulses, sync_error unchanged.
REQ-023 position_sync in ACTIVE or DEAD (early sync) sets sync_error=1 and enters DEAD with DEAD_TIME reloaded; on exit it resumes at mux_index=0, slice_index=0 with slice_start pulsed.
REQ-024 position_sync together with column_ready: sync wins and column_ready is dropped.
REQ-025 enable=0 in any state: next state is IDLE, mux_out=0 and indices cleared the next cycle.
REQ-026 sync_error clears only on rst or when enable=0.
REQ-027 Counters wrap only as specified above; no arithmetic overflow occurs for legal parameters.

Reset
REQ-028 While rst=1: state=IDLE, mux_out=0, mux_index=0, slice_index=0, slice_start=0, sync_error=0, dead counter=0.
REQ-029 Reset asserted mid-DEAD or mid-ACTIVE takes effect immediately (asynchronously); after release the block needs a fresh position_sync.

Structure
REQ-030 The FSM state enum and the default NB_MUX/NB_SLICES constants reside in the shared spirose package, also used by driver_controller and framebuffer_emulator.
REQ-031 The block is a single module with no sub-modules; the dead-time counter is inline.

Verification
REQ-032 Reset release, enable=1, position_sync at cycle 10 -> mux_out=8'h01 at cycle 11, slice_start=1 at cycle 11.
REQ-033 column_ready in ACTIVE line 0 -> mux_out=0 for exactly 4 cycles, then 8'h02, mux_index=1.
REQ-034 8 column_ready pulses (each followed by its dead time) -> mux_out returns to 8'h01, slice_index=1, single slice_start pulse.
REQ-035 128x8 columns -> WAIT_SYNC with mux_out=0; position_sync -> 8'h01, slice_index=0, sync_error=0.
REQ-036 position_sync at slice 5 line 3 together with column_ready -> sync_error=1, 4 dead cycles, 8'h01, slice_index=0; then enable=0 -> sync_error=0 and mux_out=0 next cycle.
REQ-037 rst pulse mid-DEAD -> all outputs zero asynchronously; column_ready after release with no position_sync -> mux_out stays 0.
